// File: rtl/cla_pkg.sv
// Shared definitions for the sequential 64-bit adder: slice width, FSM encoding
// and the 4-bit lookahead carry equations used by the 16-bit slice.
package cla_pkg;

   localparam int SLICE_W = 16;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_RUN  = RUN,
      ST_DONE = DONE
   } state_t;

   // Returns carries c0..c4 of a 4-wide propagate/generate group, all in two levels.
   function automatic logic [4:0] cla4(input logic [3:0] p, input logic [3:0] g, input logic c0);
      logic [4:0] c;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

endpackage

// File: rtl/cla_16_bit.sv
// Two-level 16-bit carry-lookahead adder: four 4-bit groups plus a group
// lookahead unit. Purely combinational.
module CLA_16_bit
   import cla_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout,
   output logic        pout,
   output logic        gout
);

   logic [15:0] p;
   logic [15:0] g;
   logic [15:0] c;
   logic [3:0]  grp_p;
   logic [3:0]  grp_g;
   logic [4:0]  grp_c;
   logic [4:0]  grp_tmp;
   logic [4:0]  bit_c;
   logic [4:0]  blk_c;

   always_comb begin
      p       = a ^ b;
      g       = a & b;
      grp_p   = '0;
      grp_g   = '0;
      grp_tmp = '0;
      for (int k = 0; k < 4; k++) begin
         grp_p[k] = &p[4*k +: 4];
         grp_tmp  = cla4(p[4*k +: 4], g[4*k +: 4], 1'b0);
         grp_g[k] = grp_tmp[4];
      end

      grp_c = cla4(grp_p, grp_g, cin);

      // Each group's internal carries start from the lookahead-supplied group carry.
      c     = '0;
      bit_c = '0;
      for (int k = 0; k < 4; k++) begin
         bit_c        = cla4(p[4*k +: 4], g[4*k +: 4], grp_c[k]);
         c[4*k +: 4]  = bit_c[3:0];
      end

      sum   = p ^ c;
      cout  = grp_c[4];
      blk_c = cla4(grp_p, grp_g, 1'b0);
      pout  = &grp_p;
      gout  = blk_c[4];
   end

endmodule

// File: rtl/cla_64_seq_adder.sv
// N-bit adder that reuses one 16-bit CLA slice over N/16 cycles, carrying
// between slices through a register, behind valid/ready handshakes.
module cla_64_seq_adder
   import cla_pkg::*;
#(
   parameter int N = 64,
   parameter int W = SLICE_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] input1,
   input  logic [N-1:0] input2,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         cout,
   output logic         overflow
);

   // state   | meaning
   // ST_IDLE | waiting for operands, in_ready=1
   // ST_RUN  | adding slice idx, one slice per cycle
   // ST_DONE | result valid, held until out_ready

   localparam int S     = N / W;
   localparam int IDX_W = (S > 1) ? $clog2(S) : 1;

   state_t             state_q,  state_d;
   logic [N-1:0]       a_q,      a_d;
   logic [N-1:0]       b_q,      b_d;
   logic [N-1:0]       result_q, result_d;
   logic               carry_q,  carry_d;
   logic               ovf_q,    ovf_d;
   logic [IDX_W-1:0]   idx_q,    idx_d;

   logic [W-1:0]       slice_a;
   logic [W-1:0]       slice_b;
   logic [W-1:0]       slice_sum;
   logic               slice_cout;
   logic               slice_p_unused;
   logic               slice_g_unused;

   CLA_16_bit u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout),
      .pout (slice_p_unused),
      .gout (slice_g_unused)
   );

   always_comb begin
      slice_a = a_q[idx_q*W +: W];
      slice_b = b_q[idx_q*W +: W];
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      idx_d     = idx_q;
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = input1;
               b_d     = input2;
               carry_d = cin;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            result_d[idx_q*W +: W] = slice_sum;
            carry_d                = slice_cout;
            idx_d                  = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(S - 1)) begin
               // Carry into the MSB is recovered from the MSB's own sum bit.
               ovf_d   = (a_q[N-1] ^ b_q[N-1] ^ slice_sum[W-1]) ^ slice_cout;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         idx_q    <= idx_d;
      end
   end

   assign result   = result_q;
   assign cout     = carry_q;
   assign overflow = ovf_q;

endmodule
